// File: rtl/gen_sync_que_mc.sv
// Multi-channel FWFT synchronous FIFO with per-channel flush, fill count and watermark flags.
// Optional sticky overflow/underflow flags are enabled by defining GEN_SYNC_QUE_MC_ERR_EN.
module gen_sync_que_mc #(
  parameter int NCH    = 4,
  parameter int DPWR   = 3,
  parameter int WD     = 32,
  parameter int AF_LVL = (1 << DPWR) - 1,
  parameter int AE_LVL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            flush_n,
  input  logic [NCH*WD-1:0]         din,
  input  logic [NCH-1:0]            push,
  input  logic [NCH-1:0]            pop,
  output logic [NCH*WD-1:0]         qout,
  output logic [NCH-1:0]            qempty,
  output logic [NCH-1:0]            qfull,
  output logic [NCH-1:0]            ok_to_push,
  output logic [NCH-1:0]            ok_to_pop,
  output logic [NCH-1:0]            almost_full,
  output logic [NCH-1:0]            almost_empty,
  output logic [NCH*(DPWR+1)-1:0]   fill
`ifdef GEN_SYNC_QUE_MC_ERR_EN
  ,
  output logic [NCH-1:0]            err_ovf,
  output logic [NCH-1:0]            err_unf
`endif
);

  localparam int DEPTH = 1 << DPWR;
  localparam int FW    = DPWR + 1;
  localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);
  localparam logic [FW-1:0] AF_C    = FW'(AF_LVL);
  localparam logic [FW-1:0] AE_C    = FW'(AE_LVL);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WD-1:0]   mem_r [DEPTH];
    logic [DPWR-1:0] wptr_r;
    logic [DPWR-1:0] rptr_r;
    logic [FW-1:0]   fill_r;
    logic            qempty_r;
    logic            qfull_r;
    logic            af_r;
    logic            ae_r;
    logic [WD-1:0]   qout_r;

    logic            push_acc_s;
    logic            pop_acc_s;
    logic [DPWR-1:0] wptr_nxt_s;
    logic [DPWR-1:0] rptr_nxt_s;
    logic [FW-1:0]   fill_nxt_s;
    logic [WD-1:0]   head_nxt_s;
    logic [WD-1:0]   din_s;

    // Next-state pointers, fill and head word for this channel
    always_comb begin
      din_s      = din[c*WD +: WD];
      push_acc_s = push[c] & ~qfull_r;
      pop_acc_s  = pop[c] & ~qempty_r;
      wptr_nxt_s = push_acc_s ? (wptr_r + {{(DPWR-1){1'b0}}, 1'b1}) : wptr_r;
      rptr_nxt_s = pop_acc_s ? (rptr_r + {{(DPWR-1){1'b0}}, 1'b1}) : rptr_r;
      case ({push_acc_s, pop_acc_s})
        2'b10:   fill_nxt_s = fill_r + {{(FW-1){1'b0}}, 1'b1};
        2'b01:   fill_nxt_s = fill_r - {{(FW-1){1'b0}}, 1'b1};
        default: fill_nxt_s = fill_r;
      endcase
      // The word being written this cycle becomes the head when the read pointer lands on it
      if (fill_nxt_s == {FW{1'b0}}) begin
        head_nxt_s = {WD{1'b0}};
      end else if (push_acc_s && (rptr_nxt_s == wptr_r)) begin
        head_nxt_s = din_s;
      end else begin
        head_nxt_s = mem_r[rptr_nxt_s];
      end
    end

    // Storage write port (not reset)
    always_ff @(posedge clk) begin
      if (push_acc_s && flush_n[c]) begin
        mem_r[wptr_r] <= din_s;
      end
    end

    // Channel state and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_r   <= {DPWR{1'b0}};
        rptr_r   <= {DPWR{1'b0}};
        fill_r   <= {FW{1'b0}};
        qempty_r <= 1'b1;
        qfull_r  <= 1'b0;
        af_r     <= 1'b0;
        ae_r     <= 1'b1;
        qout_r   <= {WD{1'b0}};
      end else if (!flush_n[c]) begin
        wptr_r   <= {DPWR{1'b0}};
        rptr_r   <= {DPWR{1'b0}};
        fill_r   <= {FW{1'b0}};
        qempty_r <= 1'b1;
        qfull_r  <= 1'b0;
        af_r     <= 1'b0;
        ae_r     <= 1'b1;
        qout_r   <= {WD{1'b0}};
      end else begin
        wptr_r   <= wptr_nxt_s;
        rptr_r   <= rptr_nxt_s;
        fill_r   <= fill_nxt_s;
        qempty_r <= (fill_nxt_s == {FW{1'b0}});
        qfull_r  <= (fill_nxt_s == DEPTH_C);
        af_r     <= (fill_nxt_s >= AF_C);
        ae_r     <= (fill_nxt_s <= AE_C);
        qout_r   <= head_nxt_s;
      end
    end

    assign qout[c*WD +: WD]   = qout_r;
    assign fill[c*FW +: FW]   = fill_r;
    assign qempty[c]          = qempty_r;
    assign qfull[c]           = qfull_r;
    assign ok_to_push[c]      = ~qfull_r;
    assign ok_to_pop[c]       = ~qempty_r;
    assign almost_full[c]     = af_r;
    assign almost_empty[c]    = ae_r;

`ifdef GEN_SYNC_QUE_MC_ERR_EN
    logic err_ovf_r;
    logic err_unf_r;

    // Sticky record of dropped pushes and ignored pops
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_ovf_r <= 1'b0;
        err_unf_r <= 1'b0;
      end else if (!flush_n[c]) begin
        err_ovf_r <= 1'b0;
        err_unf_r <= 1'b0;
      end else begin
        err_ovf_r <= err_ovf_r | (push[c] & qfull_r);
        err_unf_r <= err_unf_r | (pop[c] & qempty_r);
      end
    end

    assign err_ovf[c] = err_ovf_r;
    assign err_unf[c] = err_unf_r;
`endif
  end

endmodule

// File: tb/tb_gen_sync_que_mc.sv
// Directed self-checking bench for gen_sync_que_mc (NCH=4, DPWR=3, WD=32).
module tb_gen_sync_que_mc;
  localparam int NCH = 4;
  localparam int DPWR = 3;
  localparam int WD = 32;
  localparam int FW = DPWR + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       flush_n;
  logic [NCH*WD-1:0]    din;
  logic [NCH-1:0]       push;
  logic [NCH-1:0]       pop;
  logic [NCH*WD-1:0]    qout;
  logic [NCH-1:0]       qempty;
  logic [NCH-1:0]       qfull;
  logic [NCH-1:0]       ok_to_push;
  logic [NCH-1:0]       ok_to_pop;
  logic [NCH-1:0]       almost_full;
  logic [NCH-1:0]       almost_empty;
  logic [NCH*FW-1:0]    fill;
`ifdef GEN_SYNC_QUE_MC_ERR_EN
  logic [NCH-1:0]       err_ovf;
  logic [NCH-1:0]       err_unf;
`endif

  int n_vec = 0;
  int n_err = 0;

  gen_sync_que_mc #(.NCH(NCH), .DPWR(DPWR), .WD(WD)) dut (
    .clk(clk), .rst_n(rst_n), .flush_n(flush_n), .din(din), .push(push), .pop(pop),
    .qout(qout), .qempty(qempty), .qfull(qfull), .ok_to_push(ok_to_push),
    .ok_to_pop(ok_to_pop), .almost_full(almost_full), .almost_empty(almost_empty),
    .fill(fill)
`ifdef GEN_SYNC_QUE_MC_ERR_EN
    , .err_ovf(err_ovf), .err_unf(err_unf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WD-1:0] q(input int c);
    return qout[c*WD +: WD];
  endfunction

  function automatic logic [FW-1:0] f(input int c);
    return fill[c*FW +: FW];
  endfunction

  task automatic setd(input int c, input logic [WD-1:0] v);
    din[c*WD +: WD] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_qout"}, 128'(qout), 128'h0);
    chk({tag, "_qempty"}, 128'(qempty), 128'hF);
    chk({tag, "_qfull"}, 128'(qfull), 128'h0);
    chk({tag, "_okpush"}, 128'(ok_to_push), 128'hF);
    chk({tag, "_okpop"}, 128'(ok_to_pop), 128'h0);
    chk({tag, "_af"}, 128'(almost_full), 128'h0);
    chk({tag, "_ae"}, 128'(almost_empty), 128'hF);
    chk({tag, "_fill"}, 128'(fill), 128'h0);
  endtask

  initial begin
    flush_n = 4'hF;
    push = 4'h0;
    pop = 4'h0;
    din = '0;
    #12;
    chk_reset("reset");
    rst_n = 1'b1;

    // ch0: first words, FWFT latency and low watermark
    push = 4'b0001;
    setd(0, 32'h11); step();
    chk("c0_okpop1", 128'(ok_to_pop[0]), 128'h1);
    chk("c0_head1", 128'(q(0)), 128'h11);
    chk("c0_fill1", 128'(f(0)), 128'h1);
    chk("c0_ae1", 128'(almost_empty[0]), 128'h1);
    chk("c0_af1", 128'(almost_full[0]), 128'h0);
    setd(0, 32'h22); step();
    chk("c0_fill2", 128'(f(0)), 128'h2);
    chk("c0_ae2", 128'(almost_empty[0]), 128'h0);
    chk("c0_af2", 128'(almost_full[0]), 128'h0);
    setd(0, 32'h33); step();
    chk("c0_fill3", 128'(f(0)), 128'h3);
    chk("c0_head3", 128'(q(0)), 128'h11);
    chk("c123_empty", 128'(qempty[3:1]), 128'h7);
    chk("c123_qout", 128'(qout[127:32]), 128'h0);
    for (int i = 0; i < 4; i++) begin
      setd(0, 32'h44 + 32'h11 * 32'(i)); step();
    end
    push = 4'b0000;
    chk("c0_fill7", 128'(f(0)), 128'h7);
    chk("c0_af7", 128'(almost_full[0]), 128'h1);
    chk("c0_ae7", 128'(almost_empty[0]), 128'h0);
    chk("c0_full7", 128'(qfull[0]), 128'h0);

    // ch1: fill to full, dropped 9th push, drain in order
    push = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      setd(1, 32'(i)); step();
    end
    chk("c1_full", 128'(qfull[1]), 128'h1);
    chk("c1_fill8", 128'(f(1)), 128'h8);
    chk("c1_okpush", 128'(ok_to_push[1]), 128'h0);
    setd(1, 32'hFF); step();
    chk("c1_drop_fill", 128'(f(1)), 128'h8);
    chk("c1_drop_head", 128'(q(1)), 128'h0);
    push = 4'b0000;
    pop = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      chk("c1_order", 128'(q(1)), 128'(i));
      step();
    end
    chk("c1_empty", 128'(qempty[1]), 128'h1);
    chk("c1_qout0", 128'(q(1)), 128'h0);
    chk("c1_fill0", 128'(f(1)), 128'h0);
    step();
    chk("c1_unf_fill", 128'(f(1)), 128'h0);
    chk("c1_unf_empty", 128'(qempty[1]), 128'h1);
    pop = 4'b0000;
`ifdef GEN_SYNC_QUE_MC_ERR_EN
    chk("c1_err_ovf", 128'(err_ovf[1]), 128'h1);
    chk("c1_err_unf", 128'(err_unf[1]), 128'h1);
    chk("c0_err_ovf", 128'(err_ovf[0]), 128'h0);
`endif

    // ch2: push+pop when full, then when empty
    push = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      setd(2, 32'hA0 + 32'(i)); step();
    end
    chk("c2_fill8", 128'(f(2)), 128'h8);
    setd(2, 32'hEE);
    pop = 4'b0100;
    step();
    chk("c2_pp_full_fill", 128'(f(2)), 128'h7);
    chk("c2_pp_full_head", 128'(q(2)), 128'hA1);
    push = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      chk("c2_drain", 128'(q(2)), 128'(32'hA0 + 32'(i)));
      step();
    end
    chk("c2_fill0", 128'(f(2)), 128'h0);
    chk("c2_empty", 128'(qempty[2]), 128'h1);
    push = 4'b0100;
    setd(2, 32'h55);
    step();
    chk("c2_pp_empty_fill", 128'(f(2)), 128'h1);
    chk("c2_pp_empty_head", 128'(q(2)), 128'h55);
    chk("c2_pp_empty_okpop", 128'(ok_to_pop[2]), 128'h1);
    push = 4'b0000;
    step();
    pop = 4'b0000;
    chk("c2_final_empty", 128'(qempty[2]), 128'h1);

    // ch3: steady push+pop across pointer wrap
    push = 4'b1000;
    setd(3, 32'h300); step();
    setd(3, 32'h301); step();
    pop = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      setd(3, 32'h302 + 32'(i)); step();
      chk("c3_fill", 128'(f(3)), 128'h2);
      chk("c3_head", 128'(q(3)), 128'(32'h301 + 32'(i)));
    end
    push = 4'b0000;
    pop = 4'b0000;

    // ch0: flush beats a simultaneous push, ch1 unaffected
    pop = 4'b0001;
    step(); step();
    pop = 4'b0000;
    chk("c0_fill5", 128'(f(0)), 128'h5);
    chk("c0_head5", 128'(q(0)), 128'h33);
    push = 4'b0011;
    setd(0, 32'hDD);
    setd(1, 32'hB0);
    flush_n = 4'b1110;
    step();
    chk("flush_fill", 128'(f(0)), 128'h0);
    chk("flush_empty", 128'(qempty[0]), 128'h1);
    chk("flush_qout", 128'(q(0)), 128'h0);
    chk("flush_ae", 128'(almost_empty[0]), 128'h1);
    chk("flush_c1_fill", 128'(f(1)), 128'h1);
    chk("flush_c1_head", 128'(q(1)), 128'hB0);
    flush_n = 4'hF;
    push = 4'b0001;
    setd(0, 32'h99);
    step();
    chk("post_flush_head", 128'(q(0)), 128'h99);
    chk("post_flush_fill", 128'(f(0)), 128'h1);

    // asynchronous reset in the middle of traffic
    push = 4'hF;
    setd(0, 32'hC0); setd(1, 32'hC1); setd(2, 32'hC2); setd(3, 32'hC3);
    step();
    chk("pre_rst_fill2", 128'(f(2)), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    push = 4'h0;
    #10;
    rst_n = 1'b1;
    step();
    chk_reset("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gen_sync_que_mc.md
Name: gen_sync_que_mc

Overview:
Multi-channel synchronous FIFO for streaming paths that need several independent queues with a common clock.
- NCH channels, each a power-of-two deep, first-word-fall-through (FWFT) queue.
- Per-channel flush, fill count, and programmable almost-full/almost-empty flags.
- Generalises the single-channel sync queue to N channels, watermark flags and a defined output-when-empty.

Parameters:
NCH, 4, number of independent channels (1..16)
DPWR, 3, log2 of per-channel depth; DEPTH = 1<<DPWR (DPWR >= 1)
WD, 32, data width per channel
AF_LVL, DEPTH-1, almost_full asserts when fill >= AF_LVL (1..DEPTH)
AE_LVL, 1, almost_empty asserts when fill <= AE_LVL (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush_n  in  NCH  per-channel synchronous flush, active low
din  in  NCH*WD  write data, channel c at [c*WD +: WD]
push  in  NCH  per-channel write request
pop  in  NCH  per-channel read acknowledge of current head word
qout  out  NCH*WD  head word per channel (FWFT)
qempty  out  NCH  channel empty
qfull  out  NCH  channel full
ok_to_push  out  NCH  equals ~qfull
ok_to_pop  out  NCH  equals ~qempty
almost_full  out  NCH  fill >= AF_LVL
almost_empty  out  NCH  fill <= AE_LVL
fill  out  NCH*(DPWR+1)  per-channel word count, channel c at [c*(DPWR+1) +: DPWR+1]

Behaviour:
- Reset values:
  - qout = 0, qempty = 1, qfull = 0, ok_to_push = 1, ok_to_pop = 0.
  - almost_full = 0, almost_empty = 1, fill = 0.
  - Internal pointers = 0. Storage array is not reset.
- Channels are fully independent; no cross-channel arbitration or shared state.
- Accept rules:
  - push_acc = push & ~qfull; push while full is dropped, storage and fill unchanged.
  - pop_acc = pop & ~qempty; pop while empty is ignored.
- Storage and pointers:
  - wptr, rptr are DPWR bits and wrap modulo DEPTH with no special case.
  - push_acc writes din to mem[wptr] and wptr+1.
  - pop_acc sets rptr+1.
- fill arithmetic:
  - +1 on push_acc only, -1 on pop_acc only, unchanged on both or neither.
  - Never exceeds DEPTH, never goes below 0.
- Flags are registered and derived from the next fill value, so they are valid in the same cycle fill updates:
  - qempty = (fill==0), qfull = (fill==DEPTH).
  - almost_full = (fill >= AF_LVL), almost_empty = (fill <= AE_LVL).
- FWFT latency:
  - A word pushed into an empty channel appears on qout and ok_to_pop rises the next cycle.
  - qout = mem[rptr] while ~qempty, forced to 0 while qempty.
- Simultaneous events:
  - Push+pop when empty: push accepted, pop ignored, fill -> 1.
  - Push+pop when full: pop accepted, push rejected (qfull was 1), fill -> DEPTH-1.
  - Push+pop otherwise: both accepted, fill unchanged, head advances.
- Flush:
  - flush_n[c]=0 clears channel c pointers, fill and flags to their reset values on the next edge.
  - Flush overrides push/pop in that cycle; other channels are unaffected.
- Reset mid-operation: all channels return immediately (asynchronously) to reset values; any in-flight push/pop is lost.

Optional Feature:
Macro GEN_SYNC_QUE_MC_ERR_EN.
- With the macro: adds outputs err_ovf[NCH] and err_unf[NCH], both sticky.
  - err_ovf sets on push & qfull; err_unf sets on pop & qempty.
  - Both clear on rst_n or that channel's flush_n; they do not affect datapath behaviour.
- Without the macro: the ports and their logic are absent; dropped pushes and pops are silent.

Test Plan:
- Reset, then NCH=4, DPWR=3: push ch0 0x11,0x22,0x33 on consecutive cycles -> ok_to_pop[0]=1 and qout ch0 = 0x11 one cycle after the first push; fill ch0 = 3; channels 1-3 stay qempty=1 with qout=0.
- Fill ch1 with 8 words 0..7 -> qfull[1]=1 after the 8th; a 9th push (0xFF) is dropped; popping 8 times returns 0..7 in order, then qempty[1]=1 and qout=0; with ERR_EN, err_ovf[1]=1.
- ch2 at fill=8: push+pop same cycle -> fill=7, the pushed word is rejected. ch2 at fill=0: push+pop -> fill=1, qout = the pushed word.
- Run 20 continuous push+pop cycles on ch3 after pre-filling 2 words -> fill stays 2, output order preserved across pointer wrap.
- AF_LVL=7, AE_LVL=1: ch0 fill 0->1->2->7 -> almost_empty 1,1,0,0 and almost_full 0,0,0,1.
- ch0 at fill=5, assert flush_n[0]=0 together with push[0] -> next cycle fill=0, qempty=1; ch1 contents unchanged. Then assert rst_n=0 mid-stream -> all outputs at reset values immediately.
